// File: rtl/vga_timing_checker.sv
// vga_timing_checker
// Receive-side sync checker for the 640x480 video path. It samples hsync/vsync,
// measures the line and frame timing, compares the measurements against the
// expected mode and reports lock, lock losses and per-frame measurements.
// All logic runs on the pixel clock.
module vga_timing_checker #(
  parameter int unsigned H_TOTAL         = 800,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned V_TOTAL         = 525,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned H_TOL           = 0,
  parameter int unsigned SYNC_ACTIVE_LOW = 1,
  parameter int unsigned LOCK_FRAMES     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic       locked,
  output logic       meas_valid,
  output logic       timing_err,
  output logic [9:0] h_period,
  output logic [9:0] h_pulse,
  output logic [9:0] v_period,
  output logic [9:0] v_pulse,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [9:0] H_TOTAL_C = 10'(H_TOTAL);
  localparam logic [9:0] H_SYNC_C  = 10'(H_SYNC);
  localparam logic [9:0] V_TOTAL_C = 10'(V_TOTAL);
  localparam logic [9:0] V_SYNC_C  = 10'(V_SYNC);
  localparam logic [9:0] H_TOL_C   = 10'(H_TOL);
  localparam logic [3:0] LOCK_C    = 4'(LOCK_FRAMES);
  localparam logic [9:0] CNT_MAX   = 10'd1023;
  // Pin level that means "sync inactive"; the synchroniser resets to it so
  // that reset release never looks like a sync edge.
  localparam logic       SYNC_IDLE = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // Saturating +1 for the 10-bit line/clock counters.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    if (v == CNT_MAX) begin
      sat_inc10 = v;
    end else begin
      sat_inc10 = v + 10'd1;
    end
  endfunction

  // Saturating +1 for the lock-loss counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'd255) begin
      sat_inc8 = v;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

  // Absolute difference of two unsigned 10-bit values.
  function automatic logic [9:0] abs_diff10(input logic [9:0] a, input logic [9:0] b);
    if (a >= b) begin
      abs_diff10 = a - b;
    end else begin
      abs_diff10 = b - a;
    end
  endfunction

  // Input path registers
  logic hs_meta_q, hs_meta_d, hs_sync_q, hs_sync_d, hs_dly_q, hs_dly_d;
  logic vs_meta_q, vs_meta_d, vs_sync_q, vs_sync_d, vs_dly_q, vs_dly_d;
  logic hs_norm_s, vs_norm_s;
  logic hs_start_s, hs_end_s, vs_start_s, vs_end_s;

  // Measurement registers
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] lcnt_q, lcnt_d;
  logic [9:0] h_period_q, h_period_d;
  logic [9:0] h_pulse_q, h_pulse_d;
  logic [9:0] v_period_q, v_period_d;
  logic [9:0] v_pulse_q, v_pulse_d;
  logic       h_seen_q, h_seen_d;
  logic       frame_bad_q, frame_bad_d;

  // Lock FSM and status registers
  state_t     state_q, state_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic       locked_q, locked_d;
  logic       meas_valid_q, meas_valid_d;
  logic       timing_err_q, timing_err_d;
  logic [7:0] err_count_q, err_count_d;

  logic timeout_s, line_bad_s, frame_match_s;

  // Synchroniser and edge-detect next values; the delay stage holds the
  // polarity-normalised level (active = 1).
  always_comb begin
    hs_meta_d = hsync_in;
    hs_sync_d = hs_meta_q;
    vs_meta_d = vsync_in;
    vs_sync_d = vs_meta_q;
    hs_norm_s = hs_sync_q ^ SYNC_IDLE;
    vs_norm_s = vs_sync_q ^ SYNC_IDLE;
    hs_dly_d  = hs_norm_s;
    vs_dly_d  = vs_norm_s;
    hs_start_s = hs_norm_s & ~hs_dly_q;
    hs_end_s   = ~hs_norm_s & hs_dly_q;
    vs_start_s = vs_norm_s & ~vs_dly_q;
    vs_end_s   = ~vs_norm_s & vs_dly_q;
  end

  // Synchroniser and edge-detect flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_meta_q <= SYNC_IDLE;
      hs_sync_q <= SYNC_IDLE;
      vs_meta_q <= SYNC_IDLE;
      vs_sync_q <= SYNC_IDLE;
      hs_dly_q  <= 1'b0;
      vs_dly_q  <= 1'b0;
    end else begin
      hs_meta_q <= hs_meta_d;
      hs_sync_q <= hs_sync_d;
      vs_meta_q <= vs_meta_d;
      vs_sync_q <= vs_sync_d;
      hs_dly_q  <= hs_dly_d;
      vs_dly_q  <= vs_dly_d;
    end
  end

  // Timeout, per-line check and end-of-frame match qualification.
  always_comb begin
    timeout_s  = (hcnt_q == CNT_MAX) || (lcnt_q == CNT_MAX);
    line_bad_s = h_seen_q && hs_start_s &&
                 ((abs_diff10(hcnt_q, H_TOTAL_C) > H_TOL_C) || (h_pulse_q != H_SYNC_C));
    // The line closed by a coincident hs_start still belongs to the ending frame.
    frame_match_s = !(frame_bad_q || line_bad_s) &&
                    (lcnt_q == V_TOTAL_C) && (v_pulse_q == V_SYNC_C);
  end

  // Clock/line counters and captured measurements. The clock counter restarts
  // at 1 so its value at the next hs_start is the line length directly.
  always_comb begin
    hcnt_d      = sat_inc10(hcnt_q);
    lcnt_d      = lcnt_q;
    h_period_d  = h_period_q;
    h_pulse_d   = h_pulse_q;
    v_period_d  = v_period_q;
    v_pulse_d   = v_pulse_q;
    h_seen_d    = h_seen_q;
    frame_bad_d = frame_bad_q;

    if (hs_start_s) begin
      hcnt_d     = 10'd1;
      h_period_d = hcnt_q;
      h_seen_d   = 1'b1;
    end else begin
      hcnt_d = sat_inc10(hcnt_q);
    end

    if (hs_end_s) begin
      h_pulse_d = hcnt_q;
    end else begin
      h_pulse_d = h_pulse_q;
    end

    // An hs_start coincident with vs_start is line 1 of the new frame.
    if (vs_start_s) begin
      v_period_d = lcnt_q;
      lcnt_d     = hs_start_s ? 10'd1 : 10'd0;
    end else if (hs_start_s) begin
      lcnt_d = sat_inc10(lcnt_q);
    end else begin
      lcnt_d = lcnt_q;
    end

    if (vs_end_s) begin
      v_pulse_d = lcnt_q;
    end else begin
      v_pulse_d = v_pulse_q;
    end

    if (vs_start_s) begin
      frame_bad_d = 1'b0;
    end else if (line_bad_s) begin
      frame_bad_d = 1'b1;
    end else begin
      frame_bad_d = frame_bad_q;
    end

    // After a timeout the next line must not be compared against stale data.
    if (timeout_s) begin
      h_seen_d = 1'b0;
    end else begin
      h_seen_d = h_seen_d;
    end
  end

  // Measurement register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q      <= 10'd0;
      lcnt_q      <= 10'd0;
      h_period_q  <= 10'd0;
      h_pulse_q   <= 10'd0;
      v_period_q  <= 10'd0;
      v_pulse_q   <= 10'd0;
      h_seen_q    <= 1'b0;
      frame_bad_q <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      lcnt_q      <= lcnt_d;
      h_period_q  <= h_period_d;
      h_pulse_q   <= h_pulse_d;
      v_period_q  <= v_period_d;
      v_pulse_q   <= v_pulse_d;
      h_seen_q    <= h_seen_d;
      frame_bad_q <= frame_bad_d;
    end
  end

  // Lock FSM next state and strobes; a timeout overrides any frame event so
  // a coincident mismatch produces only one error pulse.
  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    locked_d     = locked_q;
    meas_valid_d = 1'b0;
    timing_err_d = 1'b0;
    err_count_d  = err_count_q;

    if (timeout_s) begin
      state_d    = ST_SEARCH;
      locked_d   = 1'b0;
      good_cnt_d = 4'd0;
      if (state_q == ST_LOCKED) begin
        timing_err_d = 1'b1;
        err_count_d  = sat_inc8(err_count_q);
      end else begin
        timing_err_d = 1'b0;
      end
    end else if (vs_start_s) begin
      case (state_q)
        ST_SEARCH: begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = 4'd0;
          locked_d   = 1'b0;
        end
        ST_ACQUIRE: begin
          meas_valid_d = 1'b1;
          if (frame_match_s) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if ((good_cnt_q + 4'd1) == LOCK_C) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end else begin
              state_d = ST_ACQUIRE;
            end
          end else begin
            good_cnt_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          meas_valid_d = 1'b1;
          if (frame_match_s) begin
            state_d = ST_LOCKED;
          end else begin
            state_d      = ST_ACQUIRE;
            timing_err_d = 1'b1;
            err_count_d  = sat_inc8(err_count_q);
            locked_d     = 1'b0;
            good_cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d    = ST_SEARCH;
          locked_d   = 1'b0;
          good_cnt_d = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Lock FSM and status output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SEARCH;
      good_cnt_q   <= 4'd0;
      locked_q     <= 1'b0;
      meas_valid_q <= 1'b0;
      timing_err_q <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      locked_q     <= locked_d;
      meas_valid_q <= meas_valid_d;
      timing_err_q <= timing_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign locked     = locked_q;
  assign meas_valid = meas_valid_q;
  assign timing_err = timing_err_q;
  assign h_period   = h_period_q;
  assign h_pulse    = h_pulse_q;
  assign v_period   = v_period_q;
  assign v_pulse    = v_pulse_q;
  assign err_count  = err_count_q;

endmodule
